// File: rtl/counter_sched.sv
// Shared CW-bit down-counter arbitrated between NREQ requesters (round-robin by default).
// Define COUNTER_SCHED_FIXED_PRI_EN for fixed priority (lowest index wins, no rr pointer).
module counter_sched #(
  parameter int NREQ = 4,
  parameter int CW   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CW-1:0]   req_count,
  input  logic                 tick,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic [CW-1:0]        cur_count
);

  // Handshake: req[i] is a level held until done[i] pulses for one cycle while
  // grant[i] is high; dropping req[i] before that aborts the wait with no done.
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COUNT,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_nxt;
  logic [IW-1:0]   sel;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic [NREQ-1:0] owner;
  logic            any_req;

  assign any_req = |req;

`ifdef COUNTER_SCHED_FIXED_PRI_EN
  always_comb begin
    sel = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) sel = IW'(k);
    end
  end
`else
  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_nxt;
  logic [IW-1:0] idx_inc;

  assign idx_inc = (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);

  // Scan downward so the last hit is the requester closest to ptr.
  always_comb begin
    int j;
    j   = 0;
    sel = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j[IW-1:0]]) sel = j[IW-1:0];
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    count_nxt = count;
`ifndef COUNTER_SCHED_FIXED_PRI_EN
    ptr_nxt   = ptr;
`endif
    unique case (state)
      S_IDLE: begin
        if (any_req) begin
          idx_nxt   = sel;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!req[idx]) begin
          state_nxt = S_IDLE;
          count_nxt = '0;
`ifndef COUNTER_SCHED_FIXED_PRI_EN
          ptr_nxt   = idx_inc;
`endif
        end else begin
          count_nxt = req_count[idx*CW +: CW];
          state_nxt = S_COUNT;
        end
      end
      S_COUNT: begin
        if (!req[idx]) begin
          state_nxt = S_IDLE;
          count_nxt = '0;
`ifndef COUNTER_SCHED_FIXED_PRI_EN
          ptr_nxt   = idx_inc;
`endif
        end else if (count == '0) begin
          state_nxt = S_DONE;
        end else if (tick) begin
          count_nxt = count - CW'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
`ifndef COUNTER_SCHED_FIXED_PRI_EN
        ptr_nxt   = idx_inc;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      count <= '0;
`ifndef COUNTER_SCHED_FIXED_PRI_EN
      ptr   <= '0;
`endif
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      count <= count_nxt;
`ifndef COUNTER_SCHED_FIXED_PRI_EN
      ptr   <= ptr_nxt;
`endif
    end
  end

  // Outputs decode straight from state so async reset clears them at once.
  assign owner     = NREQ'(1) << idx;
  assign grant     = (state != S_IDLE) ? owner : '0;
  assign done      = (state == S_DONE) ? owner : '0;
  assign busy      = (state != S_IDLE);
  assign cur_count = count;

endmodule
